// File: rtl/mem_handshake_ram_pkg.sv
// mem_handshake_ram_pkg: shared FSM encoding, access-type constants and memory depth
// for mem_handshake_ram and its storage array.
package mem_handshake_ram_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;
    localparam logic WB_WORD   = 1'b1;
    localparam logic WB_BYTE   = 1'b0;
    localparam int   MEM_DEPTH = 256;
    function automatic logic [7:0] word_base(input logic [7:0] a);
        return {a[7:2], 2'b00};
    endfunction
endpackage

// File: rtl/mem_array_256x8.sv
// mem_array_256x8: 256 x 8-bit big-endian storage with a byte-lane write and a 4-byte read.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   word_i   1 = write 4 bytes at addr_i..addr_i+3, 0 = write wdata_i[7:0] to addr_i
//   addr_i   byte address (word accesses must already be aligned by the caller)
//   wdata_i  write data, byte mem[addr_i] taken from bits 31:24 for words
//   rdata_o  {mem[a], mem[a+1], mem[a+2], mem[a+3]} (combinational)
module mem_array_256x8 import mem_handshake_ram_pkg::*; (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic        word_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    // Contents survive reset; power-up value is all zero.
    logic [7:0] mem_q [MEM_DEPTH] = '{default: 8'h00};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (word_i || i == 0)
                    mem_q[addr_i + 8'(i)] <= word_i ? wdata_i[31 - 8*i -: 8] : wdata_i[7:0];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign rdata_o[31 - 8*g -: 8] = mem_q[addr_i + 8'(g)];
    end
endmodule

// File: rtl/mem_handshake_ram.sv
// mem_handshake_ram: MFA/MFC handshake front end for a 256-byte big-endian RAM with
// programmable wait states.
// Optional macro: MEM_ALIGN_CHECK_EN adds ALIGN_ERR and rejects misaligned word accesses.
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   MFA                  CPU request, held until MFC
//   READ_WRITE           1 = read, 0 = write (latched with MFA)
//   WORD_BYTE            1 = word, 0 = byte (latched with MFA)
//   MEMADD               byte address
//   MEMDAT_IN            write data (bytes use bits 7:0)
//   MEMDAT_OUT           read data, held through DONE
//   MEMLOAD / MEMSTORE   one-cycle read / write strobes
//   MFC                  memory function complete
//   ALIGN_ERR            misaligned word flag (MEM_ALIGN_CHECK_EN only)
module mem_handshake_ram import mem_handshake_ram_pkg::*; #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        READ_WRITE,
    input  logic        WORD_BYTE,
    input  logic [7:0]  MEMADD,
    input  logic [31:0] MEMDAT_IN,
    output logic [31:0] MEMDAT_OUT,
    output logic        MEMLOAD,
    output logic        MEMSTORE,
    output logic        MFC
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        ALIGN_ERR
`endif
);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        wb_q, wb_d;
    logic        memload_q, memload_d;
    logic        memstore_q, memstore_d;
    logic        mfc_q, mfc_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] rdata;
    logic [7:0]  arr_addr;
    logic        we;
    logic        misalign;

`ifdef MEM_ALIGN_CHECK_EN
    logic aerr_q, aerr_d;
    assign misalign  = (wb_q == WB_WORD) && (addr_q[1:0] != 2'b00);
    assign ALIGN_ERR = aerr_q;
`else
    assign misalign = 1'b0;
`endif

    // Word accesses always hit the aligned word; misaligned ones are suppressed above when checked.
    assign arr_addr = (wb_q == WB_WORD) ? word_base(addr_q) : addr_q;

    mem_array_256x8 u_array (
        .clk_i   (Clk),
        .we_i    (we),
        .word_i  (wb_q == WB_WORD),
        .addr_i  (arr_addr),
        .wdata_i (MEMDAT_IN),
        .rdata_o (rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rw_q       <= RW_READ;
            wb_q       <= WB_WORD;
            memload_q  <= 1'b0;
            memstore_q <= 1'b0;
            mfc_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wb_q       <= wb_d;
            memload_q  <= memload_d;
            memstore_q <= memstore_d;
            mfc_q      <= mfc_d;
            dout_q     <= dout_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            aerr_q <= 1'b0;
        else
            aerr_q <= aerr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wb_d    = wb_q;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    state_d = (WAIT_CYCLES == 0) ? XFER : WAIT;
                    cnt_d   = WAIT_LOAD;
                    addr_d  = MEMADD;
                    rw_d    = READ_WRITE;
                    wb_d    = WORD_BYTE;
                end
            end
            WAIT: begin
                if (!MFA) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            XFER:    state_d = MFA ? DONE : IDLE;
            DONE:    state_d = MFA ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and MFC are registered from the current state, so each lags its state by one
    // cycle; MFC therefore first appears on the second DONE cycle, keeping it disjoint from strobes.
    always_comb begin
        memload_d  = (state_q == XFER) && MFA && (rw_q == RW_READ);
        memstore_d = (state_q == XFER) && MFA && (rw_q == RW_WRITE);
        mfc_d      = (state_q == DONE) && MFA;
        // The write commits at XFER's closing edge even if MFA has just dropped.
        we         = (state_q == XFER) && (rw_q == RW_WRITE) && !misalign;
        dout_d     = !memload_d ? dout_q :
                     misalign ? 32'h0 :
                     (wb_q == WB_BYTE) ? {24'h0, rdata[31:24]} : rdata;
`ifdef MEM_ALIGN_CHECK_EN
        aerr_d     = mfc_d && misalign;
`endif
    end

    assign MEMDAT_OUT = dout_q;
    assign MEMLOAD    = memload_q;
    assign MEMSTORE   = memstore_q;
    assign MFC        = mfc_q;
endmodule

// File: tb/tb_mem_handshake_ram.sv
// tb_mem_handshake_ram: randomized self-checking bench for mem_handshake_ram (WAIT_CYCLES 2 and 0).
module tb_mem_handshake_ram;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mfa [2];
    logic        rw [2];
    logic        wb [2];
    logic [7:0]  addr [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];
    logic        load [2];
    logic        store [2];
    logic        mfc [2];
`ifdef MEM_ALIGN_CHECK_EN
    logic        aerr_o [2];
`endif
    logic [7:0]  rmem [2][256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_handshake_ram #(.WAIT_CYCLES(W0)) u0 (
        .Clk(clk), .Reset(rst), .MFA(mfa[0]), .READ_WRITE(rw[0]), .WORD_BYTE(wb[0]),
        .MEMADD(addr[0]), .MEMDAT_IN(din[0]), .MEMDAT_OUT(dout[0]),
        .MEMLOAD(load[0]), .MEMSTORE(store[0]), .MFC(mfc[0])
`ifdef MEM_ALIGN_CHECK_EN
        , .ALIGN_ERR(aerr_o[0])
`endif
    );

    mem_handshake_ram #(.WAIT_CYCLES(W1)) u1 (
        .Clk(clk), .Reset(rst), .MFA(mfa[1]), .READ_WRITE(rw[1]), .WORD_BYTE(wb[1]),
        .MEMADD(addr[1]), .MEMDAT_IN(din[1]), .MEMDAT_OUT(dout[1]),
        .MEMLOAD(load[1]), .MEMSTORE(store[1]), .MFC(mfc[1])
`ifdef MEM_ALIGN_CHECK_EN
        , .ALIGN_ERR(aerr_o[1])
`endif
    );

    function automatic bit mis(bit word, logic [7:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return word && (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_rd(int d, bit word, logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        if (mis(word, a)) return 32'h0;
        if (!word) return {24'h0, rmem[d][a]};
        return {rmem[d][b], rmem[d][b + 8'd1], rmem[d][b + 8'd2], rmem[d][b + 8'd3]};
    endfunction

    task automatic model_wr(int d, bit word, logic [7:0] a, logic [31:0] wd);
        logic [7:0] b;
        b = a & 8'hFC;
        if (mis(word, a)) return;
        if (!word) rmem[d][a] = wd[7:0];
        else for (int i = 0; i < 4; i++) rmem[d][b + 8'(i)] = wd[31 - 8*i -: 8];
    endtask

    // {latency, loads, stores, overlap, held, released, align flag}
    function automatic logic [19:0] exp_obs(int d, bit rd, bit word, logic [7:0] a);
        return {8'(d == 0 ? W0 + 2 : W1 + 2), rd ? 4'd1 : 4'd0, rd ? 4'd0 : 4'd1,
                1'b0, 1'b1, 1'b1, mis(word, a)};
    endfunction

    // One complete handshake; returns observations and the data seen with MEMLOAD.
    task automatic access(input int d, input bit rd, input bit word, input logic [7:0] a,
                          input logic [31:0] wd, output logic [19:0] obs, output logic [31:0] dat);
        int lat, nload, nstore;
        bit ovl, held, rel, ae;
        logic [31:0] hold_val;
        mfa[d] = 1'b1; rw[d] = rd; wb[d] = word; addr[d] = a; din[d] = wd;
        lat = -1; nload = 0; nstore = 0; ovl = 0; held = 1; rel = 0; ae = 0; dat = 'x;
        hold_val = '0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (load[d]) begin nload++; dat = dout[d]; end
            if (store[d]) nstore++;
            if ($countones({load[d], store[d], mfc[d]}) > 1) ovl = 1;
            if (mfc[d]) begin
                lat = i;
                hold_val = dout[d];
`ifdef MEM_ALIGN_CHECK_EN
                ae = aerr_o[d];
`endif
            end
        end
        if (lat >= 0) begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                if (!mfc[d] || dout[d] !== hold_val || load[d] || store[d]) held = 0;
            end
        end
        mfa[d] = 1'b0;
        @(posedge clk); #1;
        rel = !mfc[d];
        obs = {8'(lat), 4'(nload), 4'(nstore), ovl, held, rel, ae};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mfa[d] = 1'b1; rw[d] = 1'($urandom); wb[d] = 1'($urandom);
            addr[d] = 8'($urandom); din[d] = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({dout[d], load[d], store[d], mfc[d]} !== 35'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %h required 0", d, {dout[d], load[d], store[d], mfc[d]});
            end
        end
        rst = 1'b0; mfa[0] = 1'b0; mfa[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_write;
        logic [19:0] obs;
        logic [31:0] dat;
        access(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, obs, dat);
        model_wr(0, 1'b1, 8'h10, 32'hDEADBEEF);
        checks++;
        if (obs !== exp_obs(0, 1'b0, 1'b1, 8'h10)) begin
            errors++;
            $display("FAIL word_write_handshake got %h required %h", obs, exp_obs(0, 1'b0, 1'b1, 8'h10));
        end
    endtask

    task automatic test_word_read;
        logic [19:0] obs;
        logic [31:0] dat;
        access(0, 1'b1, 1'b1, 8'h10, 32'h0, obs, dat);
        checks++;
        if (obs !== exp_obs(0, 1'b1, 1'b1, 8'h10)) begin
            errors++;
            $display("FAIL word_read_handshake got %h required %h", obs, exp_obs(0, 1'b1, 1'b1, 8'h10));
        end
        checks++;
        if (dat !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_read_data got %h required DEADBEEF", dat);
        end
    endtask

    task automatic test_byte;
        logic [19:0] obs;
        logic [31:0] dat;
        access(0, 1'b0, 1'b0, 8'h12, 32'hFFFFFF55, obs, dat);
        model_wr(0, 1'b0, 8'h12, 32'hFFFFFF55);
        checks++;
        if (obs !== exp_obs(0, 1'b0, 1'b0, 8'h12)) begin
            errors++;
            $display("FAIL byte_write_handshake got %h required %h", obs, exp_obs(0, 1'b0, 1'b0, 8'h12));
        end
        access(0, 1'b1, 1'b0, 8'h12, 32'h0, obs, dat);
        checks++;
        if (dat !== 32'h00000055) begin
            errors++;
            $display("FAIL byte_read_data got %h required 00000055", dat);
        end
        access(0, 1'b1, 1'b1, 8'h10, 32'h0, obs, dat);
        checks++;
        if (dat !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL word_after_byte_data got %h required DEAD55EF", dat);
        end
    endtask

    task automatic test_abort;
        logic [19:0] obs;
        logic [31:0] dat;
        bit bad;
        bad = 0;
        mfa[0] = 1'b1; rw[0] = 1'b0; wb[0] = 1'b1; addr[0] = 8'h20; din[0] = 32'h12345678;
        @(posedge clk); #1;
        mfa[0] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mfc[0] || store[0]) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_mfc got %0b required 0", bad);
        end
        access(0, 1'b1, 1'b1, 8'h20, 32'h0, obs, dat);
        checks++;
        if (dat !== model_rd(0, 1'b1, 8'h20)) begin
            errors++;
            $display("FAIL abort_mem_unchanged got %h required %h", dat, model_rd(0, 1'b1, 8'h20));
        end
        mfa[0] = 1'b1; rw[0] = 1'b1; wb[0] = 1'b1; addr[0] = 8'h10;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({dout[0], load[0], store[0], mfc[0]} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_read got %h required 0", {dout[0], load[0], store[0], mfc[0]});
        end
        rst = 1'b0; mfa[0] = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b1, 8'h10, 32'h0, obs, dat);
        checks++;
        if (dat !== model_rd(0, 1'b1, 8'h10)) begin
            errors++;
            $display("FAIL mem_kept_after_reset got %h required %h", dat, model_rd(0, 1'b1, 8'h10));
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] obs;
        logic [31:0] dat, wd;
        wd = $urandom;
        access(1, 1'b0, 1'b1, 8'hFC, wd, obs, dat);
        model_wr(1, 1'b1, 8'hFC, wd);
        for (int n = 0; n < 2; n++) begin
            access(1, 1'b1, 1'b1, 8'hFC, 32'h0, obs, dat);
            checks++;
            if (obs !== exp_obs(1, 1'b1, 1'b1, 8'hFC)) begin
                errors++;
                $display("FAIL b2b_handshake_%0d got %h required %h", n, obs, exp_obs(1, 1'b1, 1'b1, 8'hFC));
            end
            checks++;
            if (dat !== wd) begin
                errors++;
                $display("FAIL b2b_data_%0d got %h required %h", n, dat, wd);
            end
        end
        access(1, 1'b1, 1'b0, 8'hFF, 32'h0, obs, dat);
        checks++;
        if (dat !== {24'h0, wd[7:0]}) begin
            errors++;
            $display("FAIL byte_ff_data got %h required %h", dat, {24'h0, wd[7:0]});
        end
    endtask

    task automatic test_align;
        logic [19:0] obs;
        logic [31:0] dat;
        access(0, 1'b0, 1'b1, 8'h11, 32'hAABBCCDD, obs, dat);
        model_wr(0, 1'b1, 8'h11, 32'hAABBCCDD);
        checks++;
        if (obs !== exp_obs(0, 1'b0, 1'b1, 8'h11)) begin
            errors++;
            $display("FAIL align_write_handshake got %h required %h", obs, exp_obs(0, 1'b0, 1'b1, 8'h11));
        end
        access(0, 1'b1, 1'b1, 8'h10, 32'h0, obs, dat);
        checks++;
        if (dat !== model_rd(0, 1'b1, 8'h10)) begin
            errors++;
            $display("FAIL align_word_10 got %h required %h", dat, model_rd(0, 1'b1, 8'h10));
        end
    endtask

    task automatic test_random;
        logic [19:0] obs;
        logic [31:0] dat, wd;
        int d;
        bit rd, word;
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 1));
            rd = 1'($urandom); word = 1'($urandom);
            a = 8'($urandom_range(8'hE0, 8'hFF));
            wd = $urandom;
            access(d, rd, word, a, wd, obs, dat);
            checks++;
            if (obs !== exp_obs(d, rd, word, a)) begin
                errors++;
                $display("FAIL rand_handshake_%0d got %h required %h", n, obs, exp_obs(d, rd, word, a));
            end
            if (rd) begin
                checks++;
                if (dat !== model_rd(d, word, a)) begin
                    errors++;
                    $display("FAIL rand_data_%0d dut%0d addr %h got %h required %h", n, d, a, dat, model_rd(d, word, a));
                end
            end else begin
                model_wr(d, word, a, wd);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mfa[d] = 1'b0; rw[d] = 1'b0; wb[d] = 1'b0; addr[d] = '0; din[d] = '0;
            for (int i = 0; i < 256; i++) rmem[d][i] = 8'h00;
        end
        rst = 1'b1;
        test_reset();
        test_word_write();
        test_word_read();
        test_byte();
        test_abort();
        test_back_to_back();
        test_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
